fpu_unit: RTL and testbench

- Single-precision (IEEE-754 binary32) floating-point add/subtract unit with a request/acknowledge handshake on both input and output.
- Sits behind the processor's instruction decode.
- Accepts one operation at a time: captures operands, computes in a fixed multi-cycle pipeline-free FSM, and holds the result until the consumer acknowledges it.
- Rounding is truncation (round toward zero).

---
 rtl/fpu_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_fpu_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_unit.sv
// Binary32 add/subtract unit, round-toward-zero, handshake FSM with fixed 4-clock latency.
// Define FPU_SUB_EN to enable command 4'h1 (data_a - data_b); otherwise it returns quiet NaN.
module fpu_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  command,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    input  logic        input_rdy,
    output logic        input_ack,
    output logic        output_rdy,
    input  logic        output_ack,
    output logic [31:0] result
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_PACK  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd24;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(23 - i);
                found = 1'b1;
            end else begin
                n     = n;
                found = found;
            end
        end
        return n;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic [7:0]         exp_q, exp_d;
    logic [23:0]        big_q, big_d, small_q, small_d;
    logic               eff_sub_q, eff_sub_d;
    logic               special_q, special_d;
    logic [31:0]        special_val_q, special_val_d;
    logic [24:0]        sum_q, sum_d;
    logic               zero_q, zero_d;
    logic signed [9:0]  nexp_q, nexp_d;
    logic [22:0]        nfrac_q, nfrac_d;
    logic               in_ack_q, in_ack_d;
    logic               out_rdy_q, out_rdy_d;
    logic [31:0]        result_q, result_d;

    logic [31:0]        b_eff_s;
    logic               cmd_ok_s;
`ifdef FPU_SUB_EN
    assign b_eff_s  = (cmd_q == 4'h1) ? {~b_q[31], b_q[30:0]} : b_q;
    assign cmd_ok_s = (cmd_q == 4'h0) || (cmd_q == 4'h1);
`else
    assign b_eff_s  = b_q;
    assign cmd_ok_s = (cmd_q == 4'h0);
`endif

    // Field classification; exponent 0 (zero or denormal) counts as zero.
    logic a_nan_s, a_inf_s, a_zero_s, b_nan_s, b_inf_s, b_zero_s;
    assign a_nan_s  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    assign a_inf_s  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    assign a_zero_s = (a_q[30:23] == 8'h00);
    assign b_nan_s  = (b_eff_s[30:23] == 8'hFF) && (b_eff_s[22:0] != 23'd0);
    assign b_inf_s  = (b_eff_s[30:23] == 8'hFF) && (b_eff_s[22:0] == 23'd0);
    assign b_zero_s = (b_eff_s[30:23] == 8'h00);

    logic        swap_s;
    logic        big_sign_s;
    logic [30:0] big_mag_s, small_mag_s;
    logic [7:0]  diff_s;
    logic [23:0] small_mant_s;
    logic [4:0]  lz_s;
    assign swap_s       = b_eff_s[30:0] > a_q[30:0];
    assign big_sign_s   = swap_s ? b_eff_s[31] : a_q[31];
    assign big_mag_s    = swap_s ? b_eff_s[30:0] : a_q[30:0];
    assign small_mag_s  = swap_s ? a_q[30:0] : b_eff_s[30:0];
    assign diff_s       = big_mag_s[30:23] - small_mag_s[30:23];
    assign small_mant_s = {1'b1, small_mag_s[22:0]};
    assign lz_s         = lzc24(sum_q[23:0]);

    // Next-state and datapath stage logic.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        a_d           = a_q;
        b_d           = b_q;
        sign_d        = sign_q;
        exp_d         = exp_q;
        big_d         = big_q;
        small_d       = small_q;
        eff_sub_d     = eff_sub_q;
        special_d     = special_q;
        special_val_d = special_val_q;
        sum_d         = sum_q;
        zero_d        = zero_q;
        nexp_d        = nexp_q;
        nfrac_d       = nfrac_q;
        in_ack_d      = in_ack_q;
        out_rdy_d     = out_rdy_q;
        result_d      = result_q;
        case (state_q)
            S_IDLE: begin
                if (input_rdy) begin
                    cmd_d    = command;
                    a_d      = data_a;
                    b_d      = data_b;
                    in_ack_d = 1'b1;
                    state_d  = S_ALIGN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_ALIGN: begin
                sign_d    = big_sign_s;
                exp_d     = big_mag_s[30:23];
                big_d     = {1'b1, big_mag_s[22:0]};
                small_d   = (diff_s >= 8'd26) ? 24'd0 : (small_mant_s >> diff_s);
                eff_sub_d = a_q[31] ^ b_eff_s[31];
                special_d = 1'b1;
                if (!cmd_ok_s) begin
                    special_val_d = QNAN;
                end else if (a_nan_s || b_nan_s) begin
                    special_val_d = QNAN;
                end else if (a_inf_s && b_inf_s) begin
                    special_val_d = (a_q[31] == b_eff_s[31]) ? a_q : QNAN;
                end else if (a_inf_s) begin
                    special_val_d = a_q;
                end else if (b_inf_s) begin
                    special_val_d = b_eff_s;
                end else if (a_zero_s) begin
                    special_val_d = b_eff_s;
                end else if (b_zero_s) begin
                    special_val_d = a_q;
                end else begin
                    special_d     = 1'b0;
                    special_val_d = 32'h0000_0000;
                end
                state_d = S_ADD;
            end
            S_ADD: begin
                if (eff_sub_q) begin
                    sum_d = {1'b0, big_q} - {1'b0, small_q};
                end else begin
                    sum_d = {1'b0, big_q} + {1'b0, small_q};
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (sum_q[24]) begin
                    zero_d  = 1'b0;
                    nexp_d  = $signed({2'b00, exp_q}) + 10'sd1;
                    nfrac_d = sum_q[23:1];
                end else if (sum_q[23:0] == 24'd0) begin
                    zero_d  = 1'b1;
                    nexp_d  = 10'sd0;
                    nfrac_d = 23'd0;
                end else begin
                    zero_d  = 1'b0;
                    nexp_d  = $signed({2'b00, exp_q}) - $signed({5'd0, lz_s});
                    nfrac_d = 23'(sum_q[22:0] << lz_s);
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                if (special_q) begin
                    result_d = special_val_q;
                end else if (zero_q) begin
                    result_d = 32'h0000_0000;
                end else if (nexp_q >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                end else if (nexp_q <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                end else begin
                    result_d = {sign_q, nexp_q[7:0], nfrac_q};
                end
                out_rdy_d = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (output_ack) begin
                    out_rdy_d = 1'b0;
                    in_ack_d  = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    state_d   = S_DONE;
                end
            end
            default: begin
                in_ack_d  = 1'b0;
                out_rdy_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cmd_q         <= 4'h0;
            a_q           <= 32'h0000_0000;
            b_q           <= 32'h0000_0000;
            sign_q        <= 1'b0;
            exp_q         <= 8'h00;
            big_q         <= 24'd0;
            small_q       <= 24'd0;
            eff_sub_q     <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= 32'h0000_0000;
            sum_q         <= 25'd0;
            zero_q        <= 1'b0;
            nexp_q        <= 10'sd0;
            nfrac_q       <= 23'd0;
            in_ack_q      <= 1'b0;
            out_rdy_q     <= 1'b0;
            result_q      <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            a_q           <= a_d;
            b_q           <= b_d;
            sign_q        <= sign_d;
            exp_q         <= exp_d;
            big_q         <= big_d;
            small_q       <= small_d;
            eff_sub_q     <= eff_sub_d;
            special_q     <= special_d;
            special_val_q <= special_val_d;
            sum_q         <= sum_d;
            zero_q        <= zero_d;
            nexp_q        <= nexp_d;
            nfrac_q       <= nfrac_d;
            in_ack_q      <= in_ack_d;
            out_rdy_q     <= out_rdy_d;
            result_q      <= result_d;
        end
    end

    assign input_ack  = in_ack_q;
    assign output_rdy = out_rdy_q;
    assign result     = result_q;

endmodule

// File: tb/tb_fpu_unit.sv
// Directed self-checking bench for fpu_unit: arithmetic vectors, specials, handshake and reset.
module tb_fpu_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  command;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        input_rdy;
    logic        input_ack;
    logic        output_rdy;
    logic        output_ack;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    fpu_unit dut (
        .clock      (clock),
        .reset      (reset),
        .command    (command),
        .data_a     (data_a),
        .data_b     (data_b),
        .input_rdy  (input_rdy),
        .input_ack  (input_ack),
        .output_rdy (output_rdy),
        .output_ack (output_ack),
        .result     (result)
    );

    always #5 clock = ~clock;

    // Issue one request; lat = clocks from the capture edge until output_rdy (20 on timeout).
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        int waited;
        @(posedge clock); #1;
        command   = cmd;
        data_a    = a;
        data_b    = b;
        input_rdy = 1'b1;
        waited    = 0;
        while (!input_ack && waited < 10) begin
            @(posedge clock); #1;
            waited++;
        end
        input_rdy = 1'b0;
        lat = 0;
        while (!output_rdy && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic pulse_ack();
        output_ack = 1'b1;
        @(posedge clock); #1;
        output_ack = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (input_ack !== 1'b0) begin errors++; $display("FAIL reset input_ack: got %b expected 0", input_ack); end
        checks++;
        if (output_rdy !== 1'b0) begin errors++; $display("FAIL reset output_rdy: got %b expected 0", output_rdy); end
        checks++;
        if (result !== 32'h0000_0000) begin errors++; $display("FAIL reset result: got %h expected 00000000", result); end
    endtask

    task automatic test_add();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] vr [8];
        int lat;
        va = '{32'h3F80_0000, 32'h41D0_0000, 32'h33D6_BF95, 32'h4040_0000,
               32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h8080_0001};
        vb = '{32'h3C23_D70A, 32'h41E8_0000, 32'h3F7F_FFFE, 32'hBF80_0000,
               32'hC040_0000, 32'h4049_0FDB, 32'hBF80_0000, 32'h0080_0000};
        vr = '{32'h3F81_47AE, 32'h425C_0000, 32'h3F7F_FFFF, 32'h4000_0000,
               32'hC000_0000, 32'h4049_0FDB, 32'h0000_0000, 32'h8000_0000};
        for (int i = 0; i < 8; i++) begin
            run_op(4'h0, va[i], vb[i], lat);
            checks++;
            if (lat !== 4) begin errors++; $display("FAIL add[%0d] latency: got %0d expected 4", i, lat); end
            checks++;
            if (result !== vr[i]) begin errors++; $display("FAIL add[%0d] result: got %h expected %h", i, result, vr[i]); end
            checks++;
            if (input_ack !== 1'b1 || output_rdy !== 1'b1) begin
                errors++; $display("FAIL add[%0d] done flags: got ack=%b rdy=%b expected 1 1", i, input_ack, output_rdy);
            end
            pulse_ack();
            checks++;
            if (input_ack !== 1'b0 || output_rdy !== 1'b0) begin
                errors++; $display("FAIL add[%0d] release: got ack=%b rdy=%b expected 0 0", i, input_ack, output_rdy);
            end
        end
    endtask

    task automatic test_sub();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vr [3];
        int lat;
        va = '{32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000};
        vb = '{32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000};
`ifdef FPU_SUB_EN
        vr = '{32'h4000_0000, 32'h0000_0000, 32'h4000_0000};
`else
        vr = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000};
`endif
        for (int i = 0; i < 3; i++) begin
            run_op(4'h1, va[i], vb[i], lat);
            checks++;
            if (lat !== 4) begin errors++; $display("FAIL sub[%0d] latency: got %0d expected 4", i, lat); end
            checks++;
            if (result !== vr[i]) begin errors++; $display("FAIL sub[%0d] result: got %h expected %h", i, result, vr[i]); end
            pulse_ack();
        end
    endtask

    task automatic test_specials();
        logic [3:0]  vc [6];
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] vr [6];
        int lat;
        vc = '{4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0};
        va = '{32'h7F80_0000, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F80_0001, 32'h7F80_0000, 32'hFF80_0000};
        vb = '{32'hFF80_0000, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hFF80_0000};
        vr = '{32'h7FC0_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000};
        for (int i = 0; i < 6; i++) begin
            run_op(vc[i], va[i], vb[i], lat);
            checks++;
            if (lat !== 4) begin errors++; $display("FAIL special[%0d] latency: got %0d expected 4", i, lat); end
            checks++;
            if (result !== vr[i]) begin errors++; $display("FAIL special[%0d] result: got %h expected %h", i, result, vr[i]); end
            pulse_ack();
        end
    endtask

    task automatic test_hold();
        int lat;
        run_op(4'h0, 32'h3F80_0000, 32'h4000_0000, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            checks++;
            if (result !== 32'h4040_0000 || output_rdy !== 1'b1) begin
                errors++; $display("FAIL hold[%0d]: got result=%h rdy=%b expected 40400000 1", i, result, output_rdy);
            end
        end
        pulse_ack();
        checks++;
        if (input_ack !== 1'b0 || output_rdy !== 1'b0) begin
            errors++; $display("FAIL hold release: got ack=%b rdy=%b expected 0 0", input_ack, output_rdy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(4'h0, 32'h4040_0000, 32'h3F80_0000, lat);
        // Acknowledge while a new request is already pending: DONE must ignore it.
        command    = 4'h0;
        data_a     = 32'h41D0_0000;
        data_b     = 32'h41E8_0000;
        input_rdy  = 1'b1;
        output_ack = 1'b1;
        @(posedge clock); #1;
        output_ack = 1'b0;
        checks++;
        if (input_ack !== 1'b0 || output_rdy !== 1'b0) begin
            errors++; $display("FAIL b2b idle: got ack=%b rdy=%b expected 0 0", input_ack, output_rdy);
        end
        @(posedge clock); #1;
        input_rdy = 1'b0;
        checks++;
        if (input_ack !== 1'b1) begin errors++; $display("FAIL b2b capture: got ack=%b expected 1", input_ack); end
        lat = 0;
        while (!output_rdy && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL b2b latency: got %0d expected 4", lat); end
        checks++;
        if (result !== 32'h425C_0000) begin errors++; $display("FAIL b2b result: got %h expected 425c0000", result); end
        pulse_ack();
    endtask

    task automatic test_reset_mid();
        int lat;
        @(posedge clock); #1;
        command   = 4'h0;
        data_a    = 32'h3F80_0000;
        data_b    = 32'h3F80_0000;
        input_rdy = 1'b1;
        @(posedge clock); #1;
        input_rdy = 1'b0;
        checks++;
        if (input_ack !== 1'b1) begin errors++; $display("FAIL midreset capture: got ack=%b expected 1", input_ack); end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        checks++;
        if (input_ack !== 1'b0 || output_rdy !== 1'b0 || result !== 32'h0000_0000) begin
            errors++; $display("FAIL midreset outputs: got ack=%b rdy=%b result=%h expected 0 0 00000000",
                               input_ack, output_rdy, result);
        end
        repeat (8) begin @(posedge clock); #1; end
        checks++;
        if (input_ack !== 1'b0 || output_rdy !== 1'b0) begin
            errors++; $display("FAIL midreset aborted: got ack=%b rdy=%b expected 0 0", input_ack, output_rdy);
        end
        run_op(4'h0, 32'h4040_0000, 32'h3F80_0000, lat);
        checks++;
        if (lat !== 4 || result !== 32'h4080_0000) begin
            errors++; $display("FAIL midreset recovery: got lat=%0d result=%h expected 4 40800000", lat, result);
        end
        pulse_ack();
    endtask

    initial begin
        reset      = 1'b0;
        command    = 4'h0;
        data_a     = 32'h0000_0000;
        data_b     = 32'h0000_0000;
        input_rdy  = 1'b0;
        output_ack = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b1;
        test_add();
        test_sub();
        test_specials();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
